// File: rtl/fpu_pkg.sv
// Shared types and constants for the float issue scoreboard.
// Latency constants give the forwarding distance of each float op class.
package fpu_pkg;

  localparam int NREG    = 32;
  localparam int REG_W   = $clog2(NREG);
  localparam int CNT_W   = 3;
  localparam int MAX_LAT = 6;
  localparam int PERF_W  = 32;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] lat_t;

  localparam lat_t LAT_MOVE = lat_t'(0);
  localparam lat_t LAT_ADSB = lat_t'(1);
  localparam lat_t LAT_MULT = lat_t'(2);
  localparam lat_t LAT_FMAD = lat_t'(4);

  // Action applied to one countdown entry in a given cycle, highest priority first.
  typedef enum logic [1:0] {
    CNT_CLEAR = 2'd0,
    CNT_LOAD  = 2'd1,
    CNT_DEC   = 2'd2,
    CNT_HOLD  = 2'd3
  } cnt_op_t;

  function automatic lat_t clamp_lat(input lat_t lat, input int max_lat);
    return (int'(lat) > max_lat) ? lat_t'(max_lat) : lat;
  endfunction

endpackage

// File: rtl/fpu_issue_scoreboard_if.sv
// Issue-stage handshake between the float decoder and the scoreboard.
// The decoder is the master; the scoreboard answers with stall/fire.
interface fpu_issue_scoreboard_if;
  import fpu_pkg::*;

  logic     issue_valid;
  logic     issue_legl;
  reg_idx_t rs1;
  reg_idx_t rs2;
  reg_idx_t rs3;
  logic     use_rs1;
  logic     use_rs2;
  logic     use_rs3;
  reg_idx_t rd;
  logic     rd_we;
  lat_t     lat;
  logic     flush;
  logic     issue_stall;
  logic     issue_fire;

  modport master (
    output issue_valid, issue_legl, rs1, rs2, rs3,
           use_rs1, use_rs2, use_rs3, rd, rd_we, lat, flush,
    input  issue_stall, issue_fire
  );

  modport slave (
    input  issue_valid, issue_legl, rs1, rs2, rs3,
           use_rs1, use_rs2, use_rs3, rd, rd_we, lat, flush,
    output issue_stall, issue_fire
  );

endinterface

// File: rtl/fpu_sb_counter.sv
// One scoreboard entry: a saturating-at-zero down-counter with load and clear.
// Clear beats load, load beats the per-cycle decrement.
module fpu_sb_counter
  import fpu_pkg::*;
#(
  parameter int CNT_W = fpu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  cnt_op_t op;

  always_comb begin
    op = CNT_HOLD;
    if (clear)
      op = CNT_CLEAR;
    else if (load)
      op = CNT_LOAD;
    else if (cnt != '0)
      op = CNT_DEC;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      unique case (op)
        CNT_CLEAR: cnt <= '0;
        CNT_LOAD:  cnt <= load_val;
        CNT_DEC:   cnt <= cnt - 1'b1;
        default:   cnt <= cnt;
      endcase
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// Table-based issue scoreboard for the float pipe: one countdown per register,
// stalls readers of pending registers, supports flush and a stall-cycle counter.
module fpu_issue_scoreboard
  import fpu_pkg::*;
#(
  parameter int NREG    = fpu_pkg::NREG,
  parameter int CNT_W   = fpu_pkg::CNT_W,
  parameter int MAX_LAT = fpu_pkg::MAX_LAT,
  parameter int PERF_W  = fpu_pkg::PERF_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  fpu_issue_scoreboard_if.slave sb,
  output logic [NREG-1:0]       pending_mask,
  output logic [PERF_W-1:0]     stall_cycles
);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  busy;
  logic [CNT_W-1:0] lat_clamped;
  logic             hazard;
  logic             alloc;

  assign lat_clamped = CNT_W'(clamp_lat(sb.lat, MAX_LAT));

  // Sources are checked against the table as it stands before this cycle's
  // allocation, so an op naming its own destination as a source never self-stalls.
  assign hazard = (sb.use_rs1 & busy[sb.rs1]) |
                  (sb.use_rs2 & busy[sb.rs2]) |
                  (sb.use_rs3 & busy[sb.rs3]);

  assign sb.issue_stall = sb.issue_valid & sb.issue_legl & hazard;
  assign sb.issue_fire  = sb.issue_valid & sb.issue_legl & ~sb.issue_stall & ~sb.flush;
  assign alloc          = sb.issue_fire & sb.rd_we;

  for (genvar g = 0; g < NREG; g++) begin : g_entry
    fpu_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (sb.flush),
      .load     (alloc && (sb.rd == reg_idx_t'(g))),
      .load_val (lat_clamped),
      .cnt      (cnt[g]),
      .busy     (busy[g])
    );
  end

  assign pending_mask = busy;

  always_ff @(posedge clk) begin
    if (!rstn)
      stall_cycles <= '0;
    else if (sb.issue_stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Randomised scoreboard bench for fpu_issue_scoreboard: a timestamp model
// predicts each cycle's outputs, a monitor pops and compares them.
module tb_fpu_issue_scoreboard;
  import fpu_pkg::*;

  typedef struct {
    bit rstn;
    bit valid;
    bit legl;
    int rs1, rs2, rs3;
    bit u1, u2, u3;
    int rd;
    bit we;
    int lat;
    bit flush;
  } stim_t;

  typedef struct {
    logic        stall;
    logic        fire;
    logic [31:0] mask;
    logic [31:0] sc;
    logic [3:0]  sc4;
    longint      cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic [31:0] pending_mask, pending_mask4;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles4;

  fpu_issue_scoreboard_if ifc ();
  fpu_issue_scoreboard_if ifc4 ();

  assign ifc4.issue_valid = ifc.issue_valid;
  assign ifc4.issue_legl  = ifc.issue_legl;
  assign ifc4.rs1         = ifc.rs1;
  assign ifc4.rs2         = ifc.rs2;
  assign ifc4.rs3         = ifc.rs3;
  assign ifc4.use_rs1     = ifc.use_rs1;
  assign ifc4.use_rs2     = ifc.use_rs2;
  assign ifc4.use_rs3     = ifc.use_rs3;
  assign ifc4.rd          = ifc.rd;
  assign ifc4.rd_we       = ifc.rd_we;
  assign ifc4.lat         = ifc.lat;
  assign ifc4.flush       = ifc.flush;

  fpu_issue_scoreboard dut (
    .clk          (clk),
    .rstn         (rstn),
    .sb           (ifc),
    .pending_mask (pending_mask),
    .stall_cycles (stall_cycles)
  );

  fpu_issue_scoreboard #(.PERF_W(4)) dut4 (
    .clk          (clk),
    .rstn         (rstn),
    .sb           (ifc4),
    .pending_mask (pending_mask4),
    .stall_cycles (stall_cycles4)
  );

  always #5 clk = ~clk;

  // Model: a register is pending in cycle c while c < ready_at[reg].
  longint ready_at [32];
  longint cyc = 0;
  longint exp_sc = 0;
  int     exp_sc4 = 0;
  bit     model_valid = 0;
  bit     last_stall = 0;
  bit     last_fire = 0;
  exp_t   exp_q [$];
  int     check_count = 0;
  int     pass_count = 0;

  function automatic bit pend(input int r);
    return ready_at[r] > cyc;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s.rstn = 1; s.valid = 0; s.legl = 1;
    s.rs1 = 0; s.rs2 = 0; s.rs3 = 0;
    s.u1 = 0; s.u2 = 0; s.u3 = 0;
    s.rd = 0; s.we = 0; s.lat = 0; s.flush = 0;
    return s;
  endfunction

  function automatic stim_t op(input int rd, input bit we, input int lat,
                               input int r1, input bit u1, input int r3, input bit u3);
    stim_t s = nop();
    s.valid = 1; s.rd = rd; s.we = we; s.lat = lat;
    s.rs1 = r1; s.u1 = u1; s.rs2 = 0; s.u2 = 0; s.rs3 = r3; s.u3 = u3;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   stall, fire;
    int   eff;
    @(negedge clk);
    rstn            = s.rstn;
    ifc.issue_valid = s.valid;
    ifc.issue_legl  = s.legl;
    ifc.rs1         = reg_idx_t'(s.rs1);
    ifc.rs2         = reg_idx_t'(s.rs2);
    ifc.rs3         = reg_idx_t'(s.rs3);
    ifc.use_rs1     = s.u1;
    ifc.use_rs2     = s.u2;
    ifc.use_rs3     = s.u3;
    ifc.rd          = reg_idx_t'(s.rd);
    ifc.rd_we       = s.we;
    ifc.lat         = lat_t'(s.lat);
    ifc.flush       = s.flush;

    stall = s.valid && s.legl &&
            ((s.u1 && pend(s.rs1)) || (s.u2 && pend(s.rs2)) || (s.u3 && pend(s.rs3)));
    fire  = s.valid && s.legl && !stall && !s.flush;
    if (model_valid) begin
      e.stall = stall;
      e.fire  = fire;
      for (int i = 0; i < 32; i++) e.mask[i] = pend(i);
      e.sc    = exp_sc[31:0];
      e.sc4   = 4'(exp_sc4);
      e.cyc   = cyc;
      exp_q.push_back(e);
    end

    if (!s.rstn) begin
      for (int i = 0; i < 32; i++) ready_at[i] = 0;
      exp_sc = 0;
      exp_sc4 = 0;
      model_valid = 1;
    end else begin
      if (s.flush) begin
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
      end else if (fire && s.we) begin
        eff = (s.lat > 6) ? 6 : s.lat;
        ready_at[s.rd] = cyc + 1 + eff;
      end
      if (stall) begin
        if (exp_sc < 64'hFFFF_FFFF) exp_sc++;
        if (exp_sc4 < 15) exp_sc4++;
      end
    end
    last_stall = stall;
    last_fire  = fire;
    cyc++;
  endtask

  task automatic issueUntilFire(input stim_t s);
    int n = 0;
    do begin
      applyStimulus(s);
      n++;
    end while (!last_fire && n < 16);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp, input longint c);
    check_count++;
    if (act !== exp)
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    else
      pass_count++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("issue_stall",   32'(ifc.issue_stall), 32'(e.stall), e.cyc);
        checkOutput("issue_fire",    32'(ifc.issue_fire),  32'(e.fire),  e.cyc);
        checkOutput("pending_mask",  pending_mask,         e.mask,       e.cyc);
        checkOutput("stall_cycles",  stall_cycles,         e.sc,         e.cyc);
        checkOutput("stall_cycles4", 32'(stall_cycles4),   32'(e.sc4),   e.cyc);
      end
    end
  end

  initial begin : driver
    stim_t s, prev;
    for (int i = 0; i < 32; i++) ready_at[i] = 0;

    s = nop(); s.rstn = 0;
    applyStimulus(s);
    applyStimulus(s);

    applyStimulus(op(3, 1, LAT_ADSB, 0, 0, 0, 0));
    repeat (2) applyStimulus(nop());

    applyStimulus(op(5, 1, LAT_MULT, 0, 0, 0, 0));
    issueUntilFire(op(6, 1, LAT_ADSB, 5, 1, 0, 0));
    repeat (3) applyStimulus(nop());

    applyStimulus(op(7, 1, LAT_FMAD, 0, 0, 0, 0));
    issueUntilFire(op(11, 1, LAT_FMAD, 1, 1, 7, 1));
    repeat (5) applyStimulus(nop());
    applyStimulus(op(7, 1, LAT_FMAD, 0, 0, 0, 0));
    applyStimulus(op(12, 1, LAT_ADSB, 1, 1, 7, 0));
    repeat (5) applyStimulus(nop());

    applyStimulus(op(9, 1, LAT_FMAD, 0, 0, 0, 0));
    s = op(10, 1, LAT_FMAD, 0, 0, 0, 0); s.flush = 1;
    applyStimulus(s);
    applyStimulus(op(13, 1, LAT_ADSB, 9, 1, 0, 0));
    repeat (2) applyStimulus(nop());

    s = op(2, 1, LAT_FMAD, 0, 0, 0, 0); s.legl = 0;
    applyStimulus(s);
    applyStimulus(op(14, 0, 0, 2, 1, 0, 0));
    applyStimulus(op(4, 1, LAT_FMAD, 0, 0, 0, 0));
    applyStimulus(op(4, 1, LAT_MOVE, 0, 0, 0, 0));
    applyStimulus(op(15, 1, LAT_ADSB, 4, 1, 0, 0));
    repeat (2) applyStimulus(nop());

    applyStimulus(op(6, 1, 7, 6, 1, 0, 0));
    issueUntilFire(op(16, 1, 0, 6, 1, 0, 0));
    applyStimulus(op(17, 1, 3, 17, 1, 17, 1));
    repeat (4) applyStimulus(nop());

    for (int k = 0; k < 5; k++) begin
      applyStimulus(op(1, 1, LAT_FMAD, 0, 0, 0, 0));
      issueUntilFire(op(18, 0, 0, 1, 1, 0, 0));
    end
    repeat (3) applyStimulus(nop());

    applyStimulus(op(8, 1, LAT_FMAD, 0, 0, 0, 0));
    s = nop(); s.rstn = 0;
    applyStimulus(s);
    applyStimulus(op(19, 1, LAT_ADSB, 8, 1, 0, 0));

    prev = nop();
    for (int n = 0; n < 3000; n++) begin
      if (last_stall) begin
        s = prev;
      end else begin
        s = nop();
        s.valid = ($urandom_range(0, 9) < 8);
        s.legl  = ($urandom_range(0, 9) < 9);
        s.rs1   = $urandom_range(0, 7);
        s.rs2   = $urandom_range(0, 7);
        s.rs3   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        s.u1    = $urandom_range(0, 1);
        s.u2    = $urandom_range(0, 1);
        s.u3    = ($urandom_range(0, 3) == 0);
        s.rd    = $urandom_range(0, 7);
        s.we    = ($urandom_range(0, 3) != 0);
        s.lat   = $urandom_range(0, 7);
      end
      s.flush = ($urandom_range(0, 99) < 3);
      s.rstn  = ($urandom_range(0, 199) != 0);
      prev = s;
      applyStimulus(s);
    end

    applyStimulus(nop());
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
